// File: rtl/accel_spi_reader.sv
// SPI mode-0 master that configures an ADXL362 and periodically burst-reads X/Y into 9-bit tilt values.
// Define ACCEL_AVG4_EN to output the mean of the last four samples instead of each raw sample.
module accel_spi_reader #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY_HZ      = 1_000_000,
  parameter int unsigned SAMPLE_FREQUENCY_HZ    = 100,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [8:0] accelX_OUT,
  output logic [8:0] accelY_OUT,
  output logic       sample_valid,
  output logic       init_done
);

  localparam int unsigned HALF_CNT   = (SIMULATE != 0) ? 2 : CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ);
  localparam int unsigned PWRUP_CNT  = (SIMULATE != 0) ? 16 : CLK_FREQUENCY_HZ / 100;
  localparam int unsigned SAMPLE_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT + 1
                                                       : CLK_FREQUENCY_HZ / SAMPLE_FREQUENCY_HZ;
  localparam int unsigned FRAME_W    = 48;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned CFG_HALVES = 2 * 24;
  localparam int unsigned RD_HALVES  = 2 * 48;
  localparam int unsigned GAP_HALVES = 2;
  localparam int unsigned OUT_W      = 9;
`ifdef ACCEL_AVG4_EN
  localparam int unsigned SMP_W      = 12;
  localparam int unsigned SUM_W      = 14;
  localparam int unsigned RX_W       = 24;
`else
  localparam int unsigned RX_W       = 18;
`endif

  localparam logic [FRAME_W-1:0] CFG_FRAME = 48'h0A2D02_000000;
  localparam logic [FRAME_W-1:0] RD_FRAME  = 48'h0B0E_0000_0000;

  typedef enum logic [2:0] {PWRUP, CFG, IDLE, RD, UPD, GAP} state_t;

  state_t                 state;
  logic [CNTR_WIDTH-1:0]  wait_cnt;
  logic [CNTR_WIDTH-1:0]  half_cnt;
  logic [CNTR_WIDTH-1:0]  sample_cnt;
  logic [IDX_W-1:0]       half_idx;
  logic                   pending;
  logic [FRAME_W-1:0]     tx_sr;
  logic [RX_W-1:0]        rx_sr;

  logic                   tick_c;
  logic                   half_end_c;
  logic [IDX_W-1:0]       last_idx_c;
  logic [IDX_W-2:0]       bit_idx_c;
  logic                   rx_keep_c;
  logic [OUT_W-1:0]       x_out_c;
  logic [OUT_W-1:0]       y_out_c;

  assign tick_c     = (sample_cnt == CNTR_WIDTH'(SAMPLE_CNT - 1));
  assign half_end_c = (half_cnt == CNTR_WIDTH'(HALF_CNT - 1));
  assign last_idx_c = (state == CFG) ? IDX_W'(CFG_HALVES) : IDX_W'(RD_HALVES);
  assign bit_idx_c  = half_idx[IDX_W-1:1];

  // Capture only the sample bits actually consumed; dummy bytes and the XH/YH upper nibbles are skipped.
  always_comb begin
    rx_keep_c = (bit_idx_c >= 6'd16)
             && !((bit_idx_c >= 6'd24) && (bit_idx_c <= 6'd27))
             && !((bit_idx_c >= 6'd40) && (bit_idx_c <= 6'd43));
`ifndef ACCEL_AVG4_EN
    if (((bit_idx_c >= 6'd21) && (bit_idx_c <= 6'd23)) ||
        ((bit_idx_c >= 6'd37) && (bit_idx_c <= 6'd39))) begin
      rx_keep_c = 1'b0;
    end
`endif
  end

`ifdef ACCEL_AVG4_EN
  logic [2:0][SMP_W-1:0] x_hist;
  logic [2:0][SMP_W-1:0] y_hist;
  logic [1:0]            fill_cnt;
  logic [SMP_W-1:0]      x_smp_c;
  logic [SMP_W-1:0]      y_smp_c;
  logic [SUM_W-1:0]      x_sum_c;
  logic [SUM_W-1:0]      y_sum_c;

  function automatic logic [SUM_W-1:0] sext(input logic [SMP_W-1:0] v);
    return {{(SUM_W - SMP_W){v[SMP_W-1]}}, v};
  endfunction

  // rx_sr holds XL, XH[3:0], YL, YH[3:0] in arrival order.
  assign x_smp_c = {rx_sr[15:12], rx_sr[23:16]};
  assign y_smp_c = {rx_sr[3:0], rx_sr[11:4]};
  assign x_sum_c = sext(x_smp_c) + sext(x_hist[0]) + sext(x_hist[1]) + sext(x_hist[2]);
  assign y_sum_c = sext(y_smp_c) + sext(y_hist[0]) + sext(y_hist[1]) + sext(y_hist[2]);
  assign x_out_c = x_sum_c[SUM_W-1:5];
  assign y_out_c = y_sum_c[SUM_W-1:5];
`else
  // rx_sr holds XL[7:3], XH[3:0], YL[7:3], YH[3:0] in arrival order.
  assign x_out_c = {rx_sr[12:9], rx_sr[17:13]};
  assign y_out_c = {rx_sr[3:0], rx_sr[8:4]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PWRUP;
      wait_cnt     <= '0;
      half_cnt     <= '0;
      sample_cnt   <= '0;
      half_idx     <= '0;
      pending      <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      spi_sclk     <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_mosi     <= 1'b0;
      accelX_OUT   <= '0;
      accelY_OUT   <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
`ifdef ACCEL_AVG4_EN
      x_hist       <= '0;
      y_hist       <= '0;
      fill_cnt     <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      sample_cnt   <= tick_c ? '0 : sample_cnt + CNTR_WIDTH'(1);
      if (tick_c && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        PWRUP: begin
          if (wait_cnt == CNTR_WIDTH'(PWRUP_CNT - 1)) begin
            wait_cnt <= '0;
            half_cnt <= '0;
            half_idx <= '0;
            spi_cs_n <= 1'b0;
            spi_mosi <= CFG_FRAME[FRAME_W-1];
            tx_sr    <= {CFG_FRAME[FRAME_W-2:0], 1'b0};
            state    <= CFG;
          end else begin
            wait_cnt <= wait_cnt + CNTR_WIDTH'(1);
          end
        end

        IDLE: begin
          if (pending || tick_c) begin
            pending  <= 1'b0;
            half_cnt <= '0;
            half_idx <= '0;
            spi_cs_n <= 1'b0;
            spi_mosi <= RD_FRAME[FRAME_W-1];
            tx_sr    <= {RD_FRAME[FRAME_W-2:0], 1'b0};
            state    <= RD;
          end
        end

        // Each half-period ends with an SCLK edge; one extra half-period after the last fall before CS rises.
        CFG, RD: begin
          if (half_end_c) begin
            half_cnt <= '0;
            if (half_idx == last_idx_c) begin
              half_idx <= '0;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              if (state == CFG) begin
                init_done <= 1'b1;
                state     <= GAP;
              end else begin
                state <= UPD;
              end
            end else begin
              half_idx <= half_idx + IDX_W'(1);
              spi_sclk <= ~spi_sclk;
              if (spi_sclk) begin
                spi_mosi <= tx_sr[FRAME_W-1];
                tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
              end else if ((state == RD) && rx_keep_c) begin
                rx_sr <= {rx_sr[RX_W-2:0], spi_miso};
              end
            end
          end else begin
            half_cnt <= half_cnt + CNTR_WIDTH'(1);
          end
        end

        UPD: begin
`ifdef ACCEL_AVG4_EN
          x_hist <= {x_hist[1:0], x_smp_c};
          y_hist <= {y_hist[1:0], y_smp_c};
          if (fill_cnt == 2'd3) begin
            accelX_OUT   <= x_out_c;
            accelY_OUT   <= y_out_c;
            sample_valid <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 2'd1;
          end
`else
          accelX_OUT   <= x_out_c;
          accelY_OUT   <= y_out_c;
          sample_valid <= 1'b1;
`endif
          half_cnt <= '0;
          half_idx <= '0;
          state    <= GAP;
        end

        GAP: begin
          if (half_end_c) begin
            half_cnt <= '0;
            if (half_idx == IDX_W'(GAP_HALVES - 1)) begin
              half_idx <= '0;
              state    <= IDLE;
            end else begin
              half_idx <= half_idx + IDX_W'(1);
            end
          end else begin
            half_cnt <= half_cnt + CNTR_WIDTH'(1);
          end
        end

        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: SPI slave model plus a scoreboard of expected tilt values.
module tb_accel_spi_reader;

`ifdef ACCEL_AVG4_EN
  localparam int SKIP = 3;
`else
  localparam int SKIP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [8:0] accelX_OUT, accelY_OUT;
  logic       sample_valid, init_done;

  always #5 clk = ~clk;

  accel_spi_reader #(
    .SIMULATE               (1),
    .SIMULATE_FREQUENCY_CNT (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .accelX_OUT   (accelX_OUT),
    .accelY_OUT   (accelY_OUT),
    .sample_valid (sample_valid),
    .init_done    (init_done)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] stim_x[$];
  logic [15:0] stim_y[$];
  logic [17:0] exp_q[$];
  logic [15:0] cur_x, cur_y;
  logic [47:0] resp, mosi_word;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic        in_txn = 1'b0, is_cfg = 1'b0, cfg_next = 1'b1, rise_mosi = 1'b0;
  int          bit_cnt = 0, valid_cnt = 0;
  int          sclk_idle_err = 0, mosi_err = 0, hold_err = 0;
  logic [8:0]  last_x = '0, last_y = '0;
  int          hx[4] = '{0, 0, 0, 0};
  int          hy[4] = '{0, 0, 0, 0};
  int          n_rd = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference conversion: arithmetic shift of the sign-extended 12-bit sample(s).
  task automatic push_expected(input logic [15:0] wx, input logic [15:0] wy);
    int sx, sy;
    sx = $signed(wx[11:0]);
    sy = $signed(wy[11:0]);
`ifdef ACCEL_AVG4_EN
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = sx;
    hy[0] = sy;
    n_rd++;
    if (n_rd >= 4)
      exp_q.push_back({9'((hx[0] + hx[1] + hx[2] + hx[3]) >>> 5),
                       9'((hy[0] + hy[1] + hy[2] + hy[3]) >>> 5)});
`else
    n_rd++;
    exp_q.push_back({9'(sx >>> 3), 9'(sy >>> 3)});
`endif
  endtask

  // One clock of slave model and scoreboard, sampled on the falling clk edge.
  task automatic step();
    logic [17:0] e;
    @(negedge clk);
    if (prev_cs && !spi_cs_n) begin
      in_txn    = 1'b1;
      is_cfg    = cfg_next;
      bit_cnt   = 0;
      mosi_word = '0;
      resp      = '0;
      if (!is_cfg) begin
        cur_x = 16'h0000;
        cur_y = 16'h0000;
        if (stim_x.size() != 0) cur_x = stim_x.pop_front();
        if (stim_y.size() != 0) cur_y = stim_y.pop_front();
        resp = {16'h0000, cur_x[7:0], cur_x[15:8], cur_y[7:0], cur_y[15:8]};
      end
      spi_miso = resp[47];
      resp     = {resp[46:0], 1'b0};
    end
    if (!spi_cs_n && !prev_sclk && spi_sclk) begin
      mosi_word = {mosi_word[46:0], spi_mosi};
      rise_mosi = spi_mosi;
      bit_cnt++;
    end else if (!spi_cs_n && prev_sclk && spi_sclk && (spi_mosi !== rise_mosi)) begin
      mosi_err++;
    end
    if (!spi_cs_n && prev_sclk && !spi_sclk) begin
      spi_miso = resp[47];
      resp     = {resp[46:0], 1'b0};
    end
    if (!prev_cs && spi_cs_n) begin
      if (reset && in_txn) begin
        if (is_cfg) begin
          check_eq("cfg_nbits", bit_cnt, 24);
          check_eq("cfg_frame", mosi_word, 48'h0A2D02);
          check_eq("init_done_set", init_done, 1);
          cfg_next = 1'b0;
        end else begin
          check_eq("rd_nbits", bit_cnt, 48);
          check_eq("rd_frame", mosi_word, 48'h0B0E_0000_0000);
          push_expected(cur_x, cur_y);
        end
      end
      in_txn = 1'b0;
    end
    if (spi_cs_n && spi_sclk) sclk_idle_err++;
    if (sample_valid) begin
      valid_cnt++;
      check_eq("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("accel_x", accelX_OUT, e[17:9]);
        check_eq("accel_y", accelY_OUT, e[8:0]);
      end
      last_x = accelX_OUT;
      last_y = accelY_OUT;
    end else if (reset && ((accelX_OUT !== last_x) || (accelY_OUT !== last_y))) begin
      hold_err++;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  endtask

  task automatic wait_pwrup(input string tag);
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (spi_cs_n && (cnt < 200));
    check_eq(tag, cnt, 16);
    check_eq("init_done_low", init_done, 0);
  endtask

  task automatic run_until_valid(input string tag, input int target);
    int guard;
    guard = 0;
    while ((valid_cnt < target) && (guard < 20000)) begin
      step();
      guard++;
    end
    check_eq(tag, valid_cnt, target);
  endtask

  logic [15:0] init_x[6] = '{16'h0123, 16'h07FF, 16'hC010, 16'h3010, 16'h0020, 16'hE020};
  logic [15:0] init_y[6] = '{16'hFF00, 16'hF800, 16'h0FFF, 16'h5801, 16'h7400, 16'h0008};
  logic [15:0] post_x[4] = '{16'h0010, 16'h0010, 16'h0020, 16'h0020};
  logic [15:0] post_y[4] = '{16'hFFF0, 16'hFFF0, 16'h07F0, 16'h0000};

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", spi_cs_n, 1);
    check_eq("rst_sclk", spi_sclk, 0);
    check_eq("rst_mosi", spi_mosi, 0);
    check_eq("rst_x", accelX_OUT, 0);
    check_eq("rst_y", accelY_OUT, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_init_done", init_done, 0);

    for (int i = 0; i < 6; i++) begin
      stim_x.push_back(init_x[i]);
      stim_y.push_back(init_y[i]);
    end
    for (int i = 0; i < 4; i++) begin
      stim_x.push_back(16'($urandom_range(0, 65535)));
      stim_y.push_back(16'($urandom_range(0, 65535)));
    end

    reset = 1'b1;
    wait_pwrup("pwrup_cycles");
    run_until_valid("reads_done", 10 - SKIP);

    // Abort a read during its fourth byte.
    guard = 0;
    while (!(in_txn && !is_cfg && (bit_cnt >= 26)) && (guard < 5000)) begin
      step();
      guard++;
    end
    check_eq("reached_byte4", bit_cnt >= 26, 1);
    reset = 1'b0;
    #1;
    check_eq("abort_cs_n", spi_cs_n, 1);
    check_eq("abort_sclk", spi_sclk, 0);
    check_eq("abort_x", accelX_OUT, 0);
    check_eq("abort_y", accelY_OUT, 0);
    check_eq("abort_init_done", init_done, 0);
    exp_q.delete();
    cfg_next = 1'b1;
    last_x   = '0;
    last_y   = '0;
    n_rd     = 0;
    hx       = '{0, 0, 0, 0};
    hy       = '{0, 0, 0, 0};
    repeat (3) step();
    stim_x.delete();
    stim_y.delete();
    for (int i = 0; i < 4; i++) begin
      stim_x.push_back(post_x[i]);
      stim_y.push_back(post_y[i]);
    end
    reset = 1'b1;
    wait_pwrup("pwrup_cycles_rerun");
    run_until_valid("reads_done_post", valid_cnt + 4 - SKIP);
    check_eq("sb_drained", exp_q.size(), 0);

    check_eq("sclk_idle_low", sclk_idle_err, 0);
    check_eq("mosi_stable_high", mosi_err, 0);
    check_eq("outputs_hold", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
- SPI master for the on-board ADXL362 3-axis accelerometer.
- After reset it configures the sensor into measurement mode, then periodically burst-reads the 12-bit X and Y data.
- Each X/Y pair is converted to 9-bit two's-complement tilt values that drive the ball-position block's accelX_IN/accelY_IN inputs.
- It is the producer end of the accelerometer-to-ball interface.

Parameters:
- CLK_FREQUENCY_HZ, 100000000, system clock frequency.
- SCLK_FREQUENCY_HZ, 1000000, SPI serial clock frequency; half-period count = CLK_FREQUENCY_HZ/(2*SCLK_FREQUENCY_HZ).
- SAMPLE_FREQUENCY_HZ, 100, read-transaction rate.
- CNTR_WIDTH, 32, width of the sample-period and power-up counters.
- SIMULATE, 0, when 1 the sample period becomes SIMULATE_FREQUENCY_CNT+1 clocks, the power-up wait becomes 16 clocks, and the SCLK half-period becomes 2 clocks.
- SIMULATE_FREQUENCY_CNT, 5, sample period count used when SIMULATE=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- spi_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  out  1  SPI chip select, active low.
- spi_mosi  out  1  master out, MSB first.
- spi_miso  in  1  master in.
- accelX_OUT  out  9  X tilt, two's complement.
- accelY_OUT  out  9  Y tilt, two's complement.
- sample_valid  out  1  one-clock pulse when accelX_OUT/accelY_OUT update.
- init_done  out  1  high once the configuration write has completed.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - accelX_OUT=0, accelY_OUT=0, sample_valid=0, init_done=0.
  - All counters cleared; FSM in PWRUP.
- FSM states:
  - PWRUP: wait 10 ms (CLK_FREQUENCY_HZ/100 clocks; 16 in SIMULATE), then go to CFG.
  - CFG: assert CS and shift 3 bytes 0x0A, 0x2D, 0x02 (write POWER_CTL = measure), then go to GAP with init_done set to 1. init_done stays 1 until reset.
  - IDLE: wait for the sample tick, then go to RD.
  - RD: assert CS and shift 6 bytes. MOSI sends 0x0B, 0x0E, then 0x00 x4. MISO bytes 3..6 are captured as XL, XH, YL, YH. Then go to UPD.
  - UPD: one clock. Load outputs, pulse sample_valid, go to GAP.
  - GAP: CS high for one full SCLK period (2 half-periods), then go to IDLE.
- SPI timing:
  - CS falls one half-period before the first SCLK rise.
  - MOSI is valid before each rising edge and changes only while SCLK is low.
  - MISO is sampled on SCLK rising edges.
  - SCLK returns low after the 8th bit of the last byte; CS rises one half-period later.
  - SCLK idles low with CS high.
  - No gaps between bytes within a transaction.
- Sample tick:
  - A free-running counter, period CLK_FREQUENCY_HZ/SAMPLE_FREQUENCY_HZ clocks, counting from reset release.
  - A tick arriving outside IDLE is latched as pending and serviced on entry to IDLE.
  - Additional ticks while one is pending are dropped; at most one is pending.
- Conversion:
  - 16-bit word = {XH,XL} (likewise Y). Bits [11:0] are the sign-extended 12-bit sample.
  - Output = word[11:3], i.e. arithmetic shift right by 3. Bit 8 is the sign.
  - The upper nibble of XH/YH is ignored.
- Outputs hold their last value between updates. X and Y always update together in the same clock.
- Reset asserted mid-transaction: CS and SCLK return to idle immediately, any partial data is discarded, and the full PWRUP/CFG sequence re-runs after release.

Optional Feature:
- Macro ACCEL_AVG4_EN.
- When defined:
  - The block keeps the last four 12-bit samples per axis.
  - The output is (sum of the 4 samples)[13:5], i.e. mean >> 3 with sign preserved via 14-bit signed sum.
  - sample_valid is suppressed for the first 3 reads after reset; the first pulse comes on the 4th read.
- When undefined: every read updates the outputs directly as described in Behaviour.

Test Plan:
- Reset release → spi_cs_n=1, spi_sclk=0, outputs 0, init_done=0; no SCLK edges during PWRUP (16 clocks in SIMULATE).
- After PWRUP → slave model captures exactly 3 bytes 0x0A, 0x2D, 0x02 in one CS window, mode 0; init_done=1 after CS rises.
- Read with slave returning XL=0x23, XH=0x01, YL=0x00, YH=0xFF (X=0x123, Y=0xF00) → sample_valid pulses once, accelX_OUT=9'h024, accelY_OUT=9'h1E0; MOSI bytes are 0x0B, 0x0E, 0x00 x4.
- Slave returns X=0x7FF, Y=0x800 → accelX_OUT=9'h0FF, accelY_OUT=9'h100; outputs stay stable until the next sample_valid.
- Reset pulsed during byte 4 of a read → CS rises that cycle, outputs 0, the next transaction observed is the CFG write again.
- With ACCEL_AVG4_EN, four reads of X = 0x010, 0x010, 0x020, 0x020 → first sample_valid on the 4th read, accelX_OUT=9'h003.
